// File: rtl/seq_alu_if.sv
// seq_alu bus: request side (start, operands, opcode) and result side
// (registered result, flags, busy/done handshake).
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    // Requester drives operands and start, observes results.
    modport master (
        output start, a, b, sel,
        input  out, carry, zero, busy, done
    );

    // The ALU itself.
    modport slave (
        input  start, a, b, sel,
        output out, carry, zero, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake.
// Opcodes 0-B and F complete in one cycle; C (multiply), D (divide) and
// E (remainder) run WIDTH shift-add / restoring-divide iterations.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier being consumed / dividend turning into quotient.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   alu_out;
    logic               alu_carry;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   fin_out;
    logic               fin_carry;

    // Single-cycle result computed straight from the live operands.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        alu_out   = '0;
        alu_carry = 1'b0;
        case (bus.sel)
            4'h0: {alu_carry, alu_out} = {1'b0, bus.a} + {1'b0, bus.b};
            4'h1: {alu_carry, alu_out} = {1'b0, bus.a} - {1'b0, bus.b};
            4'h2: alu_out = bus.a & bus.b;
            4'h3: alu_out = bus.a | bus.b;
            4'h4: alu_out = bus.a ^ bus.b;
            4'h5: alu_out = ~bus.a;
            4'h6: begin
                alu_out   = {bus.a[WIDTH-2:0], 1'b0};
                alu_carry = bus.a[WIDTH-1];
            end
            4'h7: begin
                alu_out   = {1'b0, bus.a[WIDTH-1:1]};
                alu_carry = bus.a[0];
            end
            4'h8: {alu_carry, alu_out} = {1'b0, bus.a} + {{WIDTH{1'b0}}, 1'b1};
            4'h9: begin
                alu_out   = bus.a - {{(WIDTH-1){1'b0}}, 1'b1};
                alu_carry = (bus.a == '0);
            end
            4'hA: alu_out = bus.a;
            4'hB: alu_out = bus.b;
            4'hF: begin
                alu_out   = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                alu_carry = (bus.a == bus.b);
            end
            default: ;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
    end

    // Final multi-cycle result; divide by zero saturates with the error flag.
    always_comb begin
        fin_out   = '0;
        fin_carry = 1'b0;
        if (sel_q == 4'hC) begin
            fin_out   = acc_q[WIDTH-1:0];
            fin_carry = |acc_q[2*WIDTH-1:WIDTH];
        end else if (b_q == '0) begin
            fin_out   = '1;
            fin_carry = 1'b1;
        end else if (sel_q == 4'hD) begin
            fin_out = acc_q[WIDTH-1:0];
        end else begin
            fin_out = acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state and datapath update for the IDLE/ITER/FIN sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.sel == 4'hC || bus.sel == 4'hD || bus.sel == 4'hE) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        sel_d   = bus.sel;
                        acc_d   = {{WIDTH{1'b0}}, (bus.sel == 4'hC) ? bus.b : bus.a};
                        cnt_d   = '0;
                        state_d = ITER;
                    end else begin
                        out_d   = alu_out;
                        carry_d = alu_carry;
                        zero_d  = (alu_out == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            ITER: begin
                if (sel_q == 4'hC) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (div_diff[WIDTH]) begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                out_d   = fin_out;
                carry_d = fin_carry;
                zero_d  = (fin_out == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16 and WIDTH=8 with a result scoreboard.
module tb_seq_alu;
    typedef struct packed {
        logic [15:0] out;
        logic        carry;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];

    logic [3:0]  sw_sel   [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                   4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
    logic [15:0] sw_out   [13] = '{16'h00CC, 16'hFF88, 16'h0022, 16'h00AA,
                                   16'h0088, 16'hFFD5, 16'h0054, 16'h0015,
                                   16'h002B, 16'h0029, 16'h002A, 16'h00A2,
                                   16'h0001};
    logic        sw_carry [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    seq_alu_if #(.WIDTH(16)) if16 ();
    seq_alu_if #(.WIDTH(8))  if8 ();

    seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] get_out(input int w);
        return (w == 8) ? {8'h00, if8.out} : if16.out;
    endfunction
    function automatic logic get_carry(input int w);
        return (w == 8) ? if8.carry : if16.carry;
    endfunction
    function automatic logic get_zero(input int w);
        return (w == 8) ? if8.zero : if16.zero;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if16.busy;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if16.done;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sel);
        if (w == 8) begin
            if8.start = st;
            if8.a     = a[7:0];
            if8.b     = b[7:0];
            if8.sel   = sel;
        end else begin
            if16.start = st;
            if16.a     = a;
            if16.b     = b;
            if16.sel   = sel;
        end
    endtask

    // Pop the oldest expected result and compare against the DUT outputs.
    task automatic check_result(input int w, input string tag);
        res_t e;
        chk({tag, " sb_has_entry"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, " out"},   32'(get_out(w)),   32'(e.out));
        chk({tag, " carry"}, 32'(get_carry(w)), 32'(e.carry));
        chk({tag, " zero"},  32'(get_zero(w)),  32'(e.zero));
    endtask

    task automatic check_reset_state(input int w, input string tag);
        chk({tag, " out"},   32'(get_out(w)),   32'd0);
        chk({tag, " carry"}, 32'(get_carry(w)), 32'd0);
        chk({tag, " zero"},  32'(get_zero(w)),  32'd0);
        chk({tag, " busy"},  32'(get_busy(w)),  32'd0);
        chk({tag, " done"},  32'(get_done(w)),  32'd0);
    endtask

    // Back-to-back single-cycle ops: one result and one done per cycle.
    task automatic sweep(input int w);
        logic [15:0] mask;
        mask = (w == 8) ? 16'h00FF : 16'hFFFF;
        for (int i = 0; i < 13; i++) begin
            drive(w, 1'b1, 16'h002A, 16'h00A2, sw_sel[i]);
            sb_q.push_back('{out: sw_out[i] & mask, carry: sw_carry[i], zero: 1'b0});
            @(negedge clk);
            chk($sformatf("w%0d op%0h done", w, sw_sel[i]), 32'(get_done(w)), 32'd1);
            chk($sformatf("w%0d op%0h busy", w, sw_sel[i]), 32'(get_busy(w)), 32'd0);
            check_result(w, $sformatf("w%0d op%0h", w, sw_sel[i]));
        end
        drive(w, 1'b0, 16'h0000, 16'h0000, 4'h0);
        @(negedge clk);
        chk($sformatf("w%0d sweep done_low", w), 32'(get_done(w)), 32'd0);
    endtask

    // One multi-cycle op; optional second start while busy must be ignored.
    task automatic mc_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sel, input logic [15:0] eo,
                         input logic ec, input logic ez, input bit poke,
                         input string tag);
        int lat = 0;
        int busy_cnt = 0;
        int extra = 0;
        drive(w, 1'b1, a, b, sel);
        sb_q.push_back('{out: eo, carry: ec, zero: ez});
        @(negedge clk);
        drive(w, 1'b0, 16'hDEAD, 16'hBEEF, sel);
        chk({tag, " busy_at_start"}, 32'(get_busy(w)), 32'd1);
        for (int k = 1; k <= w + 4; k++) begin
            if (poke && k == 3) drive(w, 1'b1, 16'h0001, 16'h0001, 4'h0);
            if (poke && k == 4) drive(w, 1'b0, 16'h0001, 16'h0001, 4'h0);
            @(negedge clk);
            if (get_done(w)) begin
                lat = k;
                break;
            end
            if (get_busy(w)) busy_cnt++;
        end
        drive(w, 1'b0, 16'h0000, 16'h0000, 4'h0);
        chk({tag, " latency"}, 32'(lat + 1), 32'(w + 1 + 1));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(w));
        chk({tag, " busy_at_done"}, 32'(get_busy(w)), 32'd0);
        if (lat == 0) begin
            void'(sb_q.pop_front());
            return;
        end
        check_result(w, tag);
        if (poke) begin
            for (int k = 0; k < w + 4; k++) begin
                @(negedge clk);
                if (get_done(w)) extra++;
            end
            chk({tag, " extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(16, 1'b0, 16'h0000, 16'h0000, 4'h0);
        drive(8,  1'b0, 16'h0000, 16'h0000, 4'h0);
        repeat (2) @(negedge clk);
        check_reset_state(16, "reset w16");
        check_reset_state(8,  "reset w8");
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=16: single-cycle sweep, multiply, overflow multiply, div, rem.
        sweep(16);
        mc_op(16, 16'h002A, 16'h00A2, 4'hC, 16'h1A94, 1'b0, 1'b0, 1'b0, "w16 mul");
        mc_op(16, 16'h0100, 16'h0100, 4'hC, 16'h0000, 1'b1, 1'b1, 1'b0, "w16 mul_ovf");
        mc_op(16, 16'h00A2, 16'h002A, 4'hD, 16'h0003, 1'b0, 1'b0, 1'b0, "w16 div");
        mc_op(16, 16'h00A2, 16'h002A, 4'hE, 16'h0024, 1'b0, 1'b0, 1'b0, "w16 rem");

        // Divide by zero with an ignored start pulse while busy.
        mc_op(16, 16'h1234, 16'h0000, 4'hD, 16'hFFFF, 1'b1, 1'b0, 1'b1, "w16 div0");

        // Abort a multiply with an asynchronous reset five cycles in.
        drive(16, 1'b1, 16'h002A, 16'h00A2, 4'hC);
        @(negedge clk);
        drive(16, 1'b0, 16'h0000, 16'h0000, 4'h0);
        repeat (4) @(negedge clk);
        chk("abort busy_before", 32'(get_busy(16)), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_state(16, "abort async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state(16, "abort released");
        drive(16, 1'b1, 16'hFFFF, 16'h0001, 4'h0);
        sb_q.push_back('{out: 16'h0000, carry: 1'b1, zero: 1'b1});
        @(negedge clk);
        drive(16, 1'b0, 16'h0000, 16'h0000, 4'h0);
        chk("post_abort add done", 32'(get_done(16)), 32'd1);
        check_result(16, "post_abort add");

        // WIDTH=8 reruns.
        sweep(8);
        mc_op(8, 16'h002A, 16'h00A2, 4'hC, 16'h0094, 1'b1, 1'b0, 1'b0, "w8 mul");
        mc_op(8, 16'h0010, 16'h0010, 4'hC, 16'h0000, 1'b1, 1'b1, 1'b0, "w8 mul_ovf");
        mc_op(8, 16'h00A2, 16'h002A, 4'hD, 16'h0003, 1'b0, 1'b0, 1'b0, "w8 div");
        mc_op(8, 16'h00A2, 16'h002A, 4'hE, 16'h0024, 1'b0, 1'b0, 1'b0, "w8 rem");

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
